// File: rtl/dpram_pkt_writer_if.sv
// Packet-writer bus: source stream in, RAM write port out.
// master = source/RAM side, slave = the writer block.
interface dpram_pkt_writer_if #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 16
);
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;
   logic                  in_ready;
   logic                  we;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [DATA_WIDTH-1:0] din;

   modport master (
      output in_valid, in_data, in_last,
      input  in_ready, we, waddr, din
   );

   modport slave (
      input  in_valid, in_data, in_last,
      output in_ready, we, waddr, din
   );
endinterface

// File: rtl/dpram_pkt_writer.sv
// Packet writer into a dual-port RAM; packets become visible to the
// read domain (wr_ptr_gray) only once completely written.
// Ports: wr_clk, rst_n (async, active-low); bus (stream in + RAM write);
// rd_ptr_gray in; wr_ptr_gray, full, drop_cnt, pkt_cnt out.
module dpram_pkt_writer #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_PKT    = 64
) (
   input  logic                wr_clk,
   input  logic                rst_n,
   dpram_pkt_writer_if.slave   bus,
   input  logic [ADDR_WIDTH:0] rd_ptr_gray,
   output logic [ADDR_WIDTH:0] wr_ptr_gray,
   output logic                full,
   output logic [15:0]         drop_cnt,
   output logic [15:0]         pkt_cnt
);
   localparam int PW = ADDR_WIDTH + 1;
   localparam int LW = $clog2(MAX_PKT + 1);

   typedef enum logic [1:0] {IDLE, WRITE, COMMIT, DROP} state_e;

   function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   state_e                state_q, state_d;
   logic [PW-1:0]         sync1_q, sync2_q, rd_bin, used;
   logic [PW-1:0]         cmt_q, cmt_d, wrk_q, wrk_d, wpg_q, wpg_d;
   logic [LW-1:0]         len_q, len_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0] din_q, din_d;
   logic [15:0]           drop_q, drop_d, pkt_q, pkt_d;
   logic                  ready, wr;

   assign rd_bin = g2b(sync2_q);
   assign used   = wrk_q - rd_bin;
   assign full   = (used == {1'b1, {ADDR_WIDTH{1'b0}}});

   always_comb begin
      state_d = state_q;
      cmt_d   = cmt_q;
      wrk_d   = wrk_q;
      wpg_d   = wpg_q;
      len_d   = len_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      din_d   = din_q;
      drop_d  = drop_q;
      pkt_d   = pkt_q;
      ready   = 1'b0;
      wr      = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready = ~full;
            if (bus.in_valid && ready) begin
               wr      = 1'b1;
               len_d   = LW'(1);
               state_d = bus.in_last ? COMMIT : WRITE;
            end
         end
         WRITE: begin
            ready = 1'b1;
            if (bus.in_valid) begin
               // No room or over-long: throw away what was written so far.
               if (full || len_q == LW'(MAX_PKT)) begin
                  wrk_d   = cmt_q;
                  drop_d  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
                  state_d = bus.in_last ? IDLE : DROP;
               end else begin
                  wr      = 1'b1;
                  len_d   = len_q + LW'(1);
                  state_d = bus.in_last ? COMMIT : WRITE;
               end
            end
         end
         COMMIT: begin
            cmt_d   = wrk_q;
            wpg_d   = wrk_q ^ (wrk_q >> 1);
            pkt_d   = pkt_q + 16'd1;
            state_d = IDLE;
         end
         DROP: begin
            ready = 1'b1;
            if (bus.in_valid && bus.in_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (wr) begin
         we_d    = 1'b1;
         waddr_d = wrk_q[ADDR_WIDTH-1:0];
         din_d   = bus.in_data;
         wrk_d   = wrk_q + PW'(1);
      end
   end

   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sync1_q <= '0;
         sync2_q <= '0;
         cmt_q   <= '0;
         wrk_q   <= '0;
         wpg_q   <= '0;
         len_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         din_q   <= '0;
         drop_q  <= '0;
         pkt_q   <= '0;
      end else begin
         state_q <= state_d;
         sync1_q <= rd_ptr_gray;
         sync2_q <= sync1_q;
         cmt_q   <= cmt_d;
         wrk_q   <= wrk_d;
         wpg_q   <= wpg_d;
         len_q   <= len_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         din_q   <= din_d;
         drop_q  <= drop_d;
         pkt_q   <= pkt_d;
      end
   end

   assign bus.in_ready = ready;
   assign bus.we       = we_q;
   assign bus.waddr    = waddr_q;
   assign bus.din      = din_q;
   assign wr_ptr_gray  = wpg_q;
   assign drop_cnt     = drop_q;
   assign pkt_cnt      = pkt_q;
endmodule

// File: tb/tb_dpram_pkt_writer.sv
// Directed bench for dpram_pkt_writer: vector table plus
// hand-written sequences for full, drop, wrap and reset cases.
module tb_dpram_pkt_writer;
   logic        wr_clk;
   logic        rst_n;
   logic [9:0]  rd_ptr_gray;
   logic [9:0]  wr_ptr_gray;
   logic        full;
   logic [15:0] drop_cnt;
   logic [15:0] pkt_cnt;

   int n_chk = 0;
   int n_err = 0;

   dpram_pkt_writer_if #(.ADDR_WIDTH(9), .DATA_WIDTH(16)) bus ();

   dpram_pkt_writer #(
      .ADDR_WIDTH(9),
      .DATA_WIDTH(16),
      .MAX_PKT(64)
   ) dut (
      .wr_clk      (wr_clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .rd_ptr_gray (rd_ptr_gray),
      .wr_ptr_gray (wr_ptr_gray),
      .full        (full),
      .drop_cnt    (drop_cnt),
      .pkt_cnt     (pkt_cnt)
   );

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   typedef struct {
      logic        v;
      logic [15:0] d;
      logic        l;
      logic        rdy;
      logic        we;
      logic [8:0]  wa;
      logic [15:0] din;
      logic [9:0]  wpg;
      logic [15:0] pkt;
   } vec_t;

   vec_t vt[8];

   function automatic logic [9:0] g(input logic [9:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge wr_clk);
      #1;
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      rd_ptr_gray  = '0;
      rst_n        = 1'b0;
      repeat (2) @(posedge wr_clk);
      #1 rst_n = 1'b1;
      #1;
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_we"}, 32'(bus.we), 0);
      chk({nm, "_waddr"}, 32'(bus.waddr), 0);
      chk({nm, "_din"}, 32'(bus.din), 0);
      chk({nm, "_wpg"}, 32'(wr_ptr_gray), 0);
      chk({nm, "_drop"}, 32'(drop_cnt), 0);
      chk({nm, "_pkt"}, 32'(pkt_cnt), 0);
      chk({nm, "_full"}, 32'(full), 0);
      chk({nm, "_ready"}, 32'(bus.in_ready), 1);
   endtask

   // Offer one word until accepted (bounded); report write after the edge.
   task automatic xfer(input logic [15:0] d, input logic l,
                       output logic wr, output logic [8:0] wa);
      bit ok = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      for (int k = 0; k < 50 && !ok; k++) begin
         if (bus.in_ready) ok = 1;
         step();
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      wr = bus.we;
      wa = bus.waddr;
      if (!ok) begin
         n_chk++;
         n_err++;
         $display("FAIL xfer_timeout got ready=0 want ready=1");
      end
   endtask

   task automatic send(input int n, input logic lst, output int nwr);
      logic       w;
      logic [8:0] a;
      nwr = 0;
      for (int i = 0; i < n; i++) begin
         xfer(16'(i + 1), (i == n - 1) ? lst : 1'b0, w, a);
         if (w) nwr++;
      end
   endtask

   initial begin
      logic       w;
      logic [8:0] a;
      logic [9:0] prev;
      int         nwr;

      vt[0] = '{1'b1, 16'd1, 1'b0, 1'b1, 1'b1, 9'd0, 16'd1, 10'd0, 16'd0};
      vt[1] = '{1'b1, 16'd2, 1'b0, 1'b1, 1'b1, 9'd1, 16'd2, 10'd0, 16'd0};
      vt[2] = '{1'b1, 16'd3, 1'b0, 1'b1, 1'b1, 9'd2, 16'd3, 10'd0, 16'd0};
      vt[3] = '{1'b1, 16'd4, 1'b1, 1'b1, 1'b1, 9'd3, 16'd4, 10'd0, 16'd0};
      vt[4] = '{1'b1, 16'd5, 1'b1, 1'b0, 1'b0, 9'd3, 16'd4, 10'd6, 16'd1};
      vt[5] = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 9'd3, 16'd4, 10'd6, 16'd1};
      vt[6] = '{1'b1, 16'd7, 1'b1, 1'b1, 1'b1, 9'd4, 16'd7, 10'd6, 16'd1};
      vt[7] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 9'd4, 16'd7, 10'd7, 16'd2};

      // Reset state and the basic 4-word packet
      do_reset();
      chk_reset("rst");
      foreach (vt[i]) begin
         bus.in_valid = vt[i].v;
         bus.in_data  = vt[i].d;
         bus.in_last  = vt[i].l;
         #1;
         chk($sformatf("v%0d_ready", i), 32'(bus.in_ready), 32'(vt[i].rdy));
         step();
         chk($sformatf("v%0d_we", i), 32'(bus.we), 32'(vt[i].we));
         chk($sformatf("v%0d_waddr", i), 32'(bus.waddr), 32'(vt[i].wa));
         chk($sformatf("v%0d_din", i), 32'(bus.din), 32'(vt[i].din));
         chk($sformatf("v%0d_wpg", i), 32'(wr_ptr_gray), 32'(vt[i].wpg));
         chk($sformatf("v%0d_pkt", i), 32'(pkt_cnt), 32'(vt[i].pkt));
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;

      // Fill the RAM completely with the read side parked at 0
      do_reset();
      for (int p = 0; p < 8; p++) send(64, 1'b1, nwr);
      step();
      chk("full_flag", 32'(full), 1);
      chk("full_ready", 32'(bus.in_ready), 0);
      chk("full_wpg", 32'(wr_ptr_gray), 32'(g(10'd512)));
      chk("full_pkt", 32'(pkt_cnt), 8);
      rd_ptr_gray = g(10'd8);
      step();
      chk("sync_edge1_full", 32'(full), 1);
      step();
      chk("sync_edge2_full", 32'(full), 0);
      chk("sync_edge2_ready", 32'(bus.in_ready), 1);

      // Bring used to 510, then a 5-word packet overflows on word 3
      send(6, 1'b1, nwr);
      step();
      chk("pre_drop_wpg", 32'(wr_ptr_gray), 32'(g(10'd518)));
      send(5, 1'b1, nwr);
      step();
      chk("ovf_writes", 32'(nwr), 2);
      chk("ovf_drop", 32'(drop_cnt), 1);
      chk("ovf_wpg", 32'(wr_ptr_gray), 32'(g(10'd518)));
      chk("ovf_pkt", 32'(pkt_cnt), 9);
      xfer(16'hABCD, 1'b1, w, a);
      chk("ovf_rewind_waddr", 32'(a), 6);
      step();
      chk("ovf_next_wpg", 32'(wr_ptr_gray), 32'(g(10'd519)));

      // Over-long packet, then exact-MAX_PKT packet
      do_reset();
      send(3, 1'b1, nwr);
      send(65, 1'b0, nwr);
      chk("long_writes", 32'(nwr), 64);
      xfer(16'h00EE, 1'b1, w, a);
      chk("long_tail_we", 32'(w), 0);
      step();
      chk("long_drop", 32'(drop_cnt), 1);
      chk("long_pkt", 32'(pkt_cnt), 1);
      chk("long_wpg", 32'(wr_ptr_gray), 32'(g(10'd3)));
      xfer(16'h0055, 1'b1, w, a);
      chk("long_next_waddr", 32'(a), 3);
      step();
      chk("long_next_wpg", 32'(wr_ptr_gray), 32'(g(10'd4)));
      chk("long_next_pkt", 32'(pkt_cnt), 2);
      send(64, 1'b1, nwr);
      step();
      chk("max_writes", 32'(nwr), 64);
      chk("max_pkt", 32'(pkt_cnt), 3);
      chk("max_wpg", 32'(wr_ptr_gray), 32'(g(10'd68)));
      chk("max_drop", 32'(drop_cnt), 1);

      // Wrap-around with 1-word packets and a draining reader
      do_reset();
      prev = '0;
      for (int i = 0; i < 1100; i++) begin
         rd_ptr_gray = g(10'(i));
         xfer(16'(i), 1'b1, w, a);
         chk("wrap_waddr", 32'(a), 32'(i % 512));
         step();
         chk("wrap_onebit", 32'($countones(wr_ptr_gray ^ prev)), 1);
         chk("wrap_wpg", 32'(wr_ptr_gray), 32'(g(10'(i + 1))));
         prev = g(10'(i + 1));
      end

      // Asynchronous reset in the middle of word 3
      do_reset();
      send(2, 1'b1, nwr);
      step();
      send(2, 1'b0, nwr);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd3;
      #2 rst_n = 1'b0;
      #1;
      chk_reset("midrst");
      bus.in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      chk("midrst_rel_wpg", 32'(wr_ptr_gray), 0);
      chk("midrst_rel_ready", 32'(bus.in_ready), 1);
      xfer(16'h0077, 1'b1, w, a);
      chk("midrst_we", 32'(w), 1);
      chk("midrst_waddr", 32'(a), 0);
      step();
      chk("midrst_wpg", 32'(wr_ptr_gray), 1);
      chk("midrst_pkt", 32'(pkt_cnt), 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
